mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer.sv | 108 ++++++++++
 tb/tb_mac_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences K operand pairs into a downstream MAC and holds the final dot product.
// Ports:
//   clk, arst_n_in                 clock (rising edge) and asynchronous active-low reset
//   start, length                  begin a dot product of 'length' products (ignored unless IDLE, length!=0)
//   op_valid/op_ready, op_a, op_b  operand pair handshake
//   mac_a, mac_b, mac_p_valid      operands and product strobe to the MAC
//   mac_input_valid                accept delayed one cycle (MAC accumulation cycle)
//   mac_accumulate_internal        0 for the first product of a dot product, 1 afterwards
//   mac_out                        running sum from the MAC
//   result_valid/result_ready, result_data  held result handshake
//   busy                           FSM not in IDLE
//   abort                          only with MAC_SEQUENCER_ABORT_EN: return to IDLE at the next edge
module mac_sequencer #(
    parameter int A_WIDTH      = 16,
    parameter int B_WIDTH      = 16,
    parameter int OUTPUT_WIDTH = 16,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                           clk,
    input  logic                           arst_n_in,
    input  logic                           start,
    input  logic        [LEN_WIDTH-1:0]    length,
    input  logic                           op_valid,
    output logic                           op_ready,
    input  logic signed [A_WIDTH-1:0]      op_a,
    input  logic signed [B_WIDTH-1:0]      op_b,
    output logic        [A_WIDTH-1:0]      mac_a,
    output logic        [B_WIDTH-1:0]      mac_b,
    output logic                           mac_p_valid,
    output logic                           mac_input_valid,
    output logic                           mac_accumulate_internal,
    input  logic signed [OUTPUT_WIDTH-1:0] mac_out,
    output logic                           result_valid,
    input  logic                           result_ready,
`ifdef MAC_SEQUENCER_ABORT_EN
    input  logic                           abort,
`endif
    output logic signed [OUTPUT_WIDTH-1:0] result_data,
    output logic                           busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic        [LEN_WIDTH-1:0]    r_rem;
    logic                           r_first;
    logic                           r_in_valid;
    logic signed [OUTPUT_WIDTH-1:0] r_result;
    logic                           w_abort;
    logic                           w_accept;
    logic                           w_launch;

`ifdef MAC_SEQUENCER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign op_ready                = r_state == RUN;
    assign w_accept                = op_valid && op_ready && !w_abort;
    assign w_launch                = r_state == IDLE && start && length != '0 && !w_abort;
    assign mac_a                   = op_a;
    assign mac_b                   = op_b;
    assign mac_p_valid             = w_accept;
    assign mac_input_valid         = r_in_valid;
    assign mac_accumulate_internal = r_in_valid && !r_first;
    assign result_valid            = r_state == HOLD;
    assign result_data             = r_result;
    assign busy                    = r_state != IDLE;

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_launch ? RUN : IDLE;
            RUN:     w_next = (w_accept && r_rem == LEN_WIDTH'(1)) ? DRAIN : RUN;
            DRAIN:   w_next = HOLD;
            HOLD:    w_next = result_ready ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_rem      <= '0;
            r_first    <= 1'b0;
            r_in_valid <= 1'b0;
            r_result   <= '0;
        end else begin
            r_in_valid <= w_accept;
            // first-product flag drops after the first accumulation cycle; a new launch re-arms it
            if (r_in_valid) r_first <= 1'b0;
            if (w_launch) begin
                r_rem   <= length;
                r_first <= 1'b1;
            end else if (w_accept) begin
                r_rem <= r_rem - LEN_WIDTH'(1);
            end
            // DRAIN is the final accumulation cycle, so mac_out already carries the full sum
            if (r_state == DRAIN && !w_abort) r_result <= mac_out;
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: scoreboard bench for mac_sequencer with a behavioural downstream MAC.
module tb_mac_sequencer;
    localparam int AW = 16;
    localparam int BW = 16;
    localparam int OW = 16;
    localparam int LW = 8;

    logic                 clk = 1'b0;
    logic                 arst_n_in = 1'b0;
    logic                 start = 1'b0;
    logic        [LW-1:0] length = '0;
    logic                 op_valid = 1'b0;
    logic                 op_ready;
    logic signed [AW-1:0] op_a = '0;
    logic signed [BW-1:0] op_b = '0;
    logic        [AW-1:0] mac_a;
    logic        [BW-1:0] mac_b;
    logic                 mac_p_valid;
    logic                 mac_input_valid;
    logic                 mac_accumulate_internal;
    logic signed [OW-1:0] mac_out;
    logic                 result_valid;
    logic                 result_ready = 1'b1;
    logic signed [OW-1:0] result_data;
    logic                 busy;
`ifdef MAC_SEQUENCER_ABORT_EN
    logic                 abort = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int sb[$];
    int va[8];
    int vb[8];

    mac_sequencer #(.A_WIDTH(AW), .B_WIDTH(BW), .OUTPUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .start(start), .length(length),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_p_valid(mac_p_valid),
        .mac_input_valid(mac_input_valid), .mac_accumulate_internal(mac_accumulate_internal),
        .mac_out(mac_out), .result_valid(result_valid), .result_ready(result_ready),
`ifdef MAC_SEQUENCER_ABORT_EN
        .abort(abort),
`endif
        .result_data(result_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // downstream MAC: product registered on p_valid, sum presented combinationally during input_valid
    logic signed [OW-1:0] m_p;
    logic signed [OW-1:0] m_acc;
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            m_p   <= '0;
            m_acc <= '0;
        end else begin
            if (mac_p_valid) m_p <= $signed(mac_a) * $signed(mac_b);
            if (mac_input_valid) m_acc <= mac_out;
        end
    end
    assign mac_out = mac_input_valid ? (mac_accumulate_internal ? m_acc + m_p : m_p) : m_acc;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // entered and left at posedge+1; drives one dot product of k pairs from va/vb
    task automatic do_run(input int k, input bit gap, input int hold, input bit poke);
        int sum = 0;
        int i = 0;
        int pulses = 0;
        int cyc = 0;
        logic signed [OW-1:0] held;
        for (int j = 0; j < k; j++) sum += va[j] * vb[j];
        sb.push_back(sum);
        result_ready = (hold == 0);
        start = 1'b1;
        length = LW'(k);
        @(posedge clk) #1;
        start = 1'b0;
        while (i < k && cyc < 200) begin
            op_valid = !(gap && cyc[0]);
            op_a = AW'(va[i]);
            op_b = BW'(vb[i]);
            @(negedge clk);
            check("op_ready_run", op_ready, 1);
            check("p_valid", mac_p_valid, op_valid);
            check("mac_ab", {mac_a, mac_b}, {op_a, op_b});
            if (mac_input_valid) begin
                check("acc_int", mac_accumulate_internal, pulses != 0);
                pulses++;
            end else check("acc_idle", mac_accumulate_internal, 0);
            if (op_valid) i++;
            cyc++;
            @(posedge clk) #1;
        end
        if (i < k) check("run_timeout", i, k);
        op_valid = 1'b0;
        @(negedge clk);
        check("drain_iv", mac_input_valid, 1);
        check("drain_rv", result_valid, 0);
        check("drain_ready", op_ready, 0);
        if (mac_input_valid) begin
            check("acc_int_last", mac_accumulate_internal, pulses != 0);
            pulses++;
        end
        @(posedge clk) #1;
        @(negedge clk);
        check("latency_rv", result_valid, 1);
        check("pulses", pulses, k);
        held = result_data;
        if (sb.size() == 0) check("sb_empty", 0, 1);
        else check("result", result_data, sb.pop_front());
        for (int c = 0; c < hold; c++) begin
            @(posedge clk) #1;
            start = poke;
            length = 8'd3;
            @(negedge clk);
            check("hold_rv", result_valid, 1);
            check("hold_data", result_data, held);
            check("hold_ready", op_ready, 0);
            check("hold_busy", busy, 1);
        end
        if (hold > 0) begin
            @(posedge clk) #1;
            result_ready = 1'b1;
            start = poke;
            @(negedge clk);
            check("release_rv", result_valid, 1);
        end
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_rv", result_valid, 0);
        @(posedge clk) #1;
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", op_ready, 0);
        check("rst_rv", result_valid, 0);
        check("rst_iv", mac_input_valid, 0);
        check("rst_data", result_data, 0);
        @(posedge clk) #1;
        arst_n_in = 1'b1;
        @(posedge clk) #1;

        va[0] = 2;  vb[0] = 3;  va[1] = 4; vb[1] = 5; va[2] = -1; vb[2] = 6;
        do_run(3, 1'b0, 0, 1'b0);
        va[0] = 7;  vb[0] = -8;
        do_run(1, 1'b0, 0, 1'b0);
        for (int j = 0; j < 4; j++) begin va[j] = 1; vb[j] = 1; end
        do_run(4, 1'b1, 0, 1'b0);
        va[0] = 5;  vb[0] = 6;  va[1] = -3; vb[1] = 2;
        do_run(2, 1'b0, 5, 1'b1);

        start = 1'b1;
        length = '0;
        @(posedge clk) #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_busy", busy, 0);
        @(posedge clk) #1;

        start = 1'b1;
        length = 8'd4;
        @(posedge clk) #1;
        start = 1'b0;
        op_valid = 1'b1;
        op_a = 16'sd1;
        op_b = 16'sd1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        arst_n_in = 1'b0;
        #1;
        check("arst_ready", op_ready, 0);
        check("arst_pv", mac_p_valid, 0);
        check("arst_iv", mac_input_valid, 0);
        check("arst_acc", mac_accumulate_internal, 0);
        check("arst_rv", result_valid, 0);
        check("arst_busy", busy, 0);
        op_valid = 1'b0;
        @(posedge clk) #1;
        arst_n_in = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_iv", mac_input_valid, 0);
        @(posedge clk) #1;
        va[0] = 3; vb[0] = 3; va[1] = 3; vb[1] = 3;
        do_run(2, 1'b0, 0, 1'b0);

`ifdef MAC_SEQUENCER_ABORT_EN
        start = 1'b1;
        length = 8'd1;
        @(posedge clk) #1;
        start = 1'b0;
        op_valid = 1'b1;
        op_a = 16'sd2;
        op_b = 16'sd2;
        @(posedge clk) #1;
        op_valid = 1'b0;
        abort = 1'b1;
        @(posedge clk) #1;
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_rv", result_valid, 0);
            check("abort_busy", busy, 0);
            @(posedge clk) #1;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
